avs_i2s_rx: RTL and testbench
=============================

# avs_i2s_rx

Avalon-MM slave I2S receiver, the capture-side counterpart of the team's I2S transmitter peripheral. It takes an external I2S stream (SCK, WS and SD driven by the codec or master) and oversamples it in the `clk` domain. Each left/right sample pair is assembled into one 32-bit frame and buffered in a small FIFO, which the CPU drains over Avalon-MM.

## Interface
- `DW`, 16: sample width per channel; legal 8..16.
- `FIFO_DEPTH`, 8: frames buffered; power of 2, 2..64.
- `clk`  in  1  system clock; must be ≥ 8× SCK frequency.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `avs_s0_address`  in  2  register select.
- `avs_s0_read`  in  1  read strobe.
- `avs_s0_write`  in  1  write strobe.
- `avs_s0_waitrequest`  out  1  tied 0.
- `avs_s0_readdata`  out  32  combinational read data.
- `avs_s0_writedata`  in  32  write data.
- `avs_s0_export_i2s_sck`  in  1  I2S bit clock, asynchronous to `clk`.
- `avs_s0_export_i2s_ws`  in  1  word select: 0 = left, 1 = right.
- `avs_s0_export_i2s_sd`  in  1  serial data, MSB first.

## Operation
- **Register map**
  - Addr 0 DATA (RO)
    - Reads return the FIFO head as {left, right}. Each channel is left-aligned in its 16-bit half; unused LSBs are 0.
    - A read pops the FIFO if it is not empty. An empty FIFO returns 0 and does not pop.
  - Addr 1 CONTROL (RW)
    - bit0 EN.
    - bit1 FLUSH: write-only; empties the FIFO; reads back 0.
    - Other bits read 0.
  - Addr 2 STATUS
    - bit0 EMPTY.
    - bit1 FULL.
    - bit2 OVERFLOW: sticky; cleared by writing 1 to bit2.
    - bit3 SYNCED.
    - bits[14:8] LEVEL.
    - Other bits read 0. Writes affect bit2 only.
  - Addr 3 reads 0; writes to it are ignored.
- Readdata is 0 whenever `avs_s0_read` = 0.
- **Input synchronisation**
  - SCK, WS and SD each pass through a 2-flop synchroniser.
  - An SCK rising edge is detected from the synchronised SCK and its previous value.
  - All capture happens only on detected rising edges.
- **Capture FSM** (advances on detected SCK rise)
  - IDLE: EN = 0. Clear the bit counter, shift register and SYNCED. Leave the FIFO untouched.
  - HUNT: EN = 1. Wait for the first WS change; SYNCED is set at that edge.
  - RUN:
    - On each edge where WS is unchanged: if cnt < DW, write SD into `sr[DW-1-cnt]` and increment cnt; cnt saturates at DW.
    - On a WS-change edge: the SD bit on this edge is the outgoing word's LSB and is stored under the same rule.
    - The completed word goes to the left holding register if the previous WS was 0, or the right holding register if it was 1.
    - Then sr and cnt are cleared.
  - Words longer than DW are truncated, keeping the MSBs. Shorter words are zero-padded in the LSBs.
- **Frame push**
  - When a right word completes and a left word has completed since the last push, push {left, right} into the FIFO.
  - A right word with no preceding left word (the first one after sync) is discarded.
- **FIFO**
  - Push while full (with no pop in the same cycle): the frame is dropped and OVERFLOW is set.
  - Push and pop in the same cycle: both are performed, and LEVEL is unchanged.
  - FLUSH takes priority over a same-cycle push and pop; the FIFO ends empty.
- Clearing EN mid-word returns the FSM to IDLE; the partial word and the left holding register are discarded.

## Timing
- All outputs are 0 in reset, except that STATUS reads 0x00000001 (EMPTY).
- Reset clears the FIFO pointers, CONTROL, OVERFLOW and the FSM (IDLE).
- From an SCK pin rise to the internal edge strobe: 3 `clk` cycles.
- The push lands 1 `clk` after the strobe that completes the right word. EMPTY and LEVEL update on the following cycle.
- DATA read: readdata is valid in the same cycle as `avs_s0_read`. The pop takes effect at that cycle's closing edge; the next read sees the next frame.
- Zero wait states; `avs_s0_waitrequest` = 0 always.
- A CONTROL write takes effect at the next edge. An EN 1→0 transition aborts capture that cycle.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-traffic.
  - Response: STATUS = 0x00000001, CONTROL = 0, DATA read = 0, waitrequest = 0.
- **Basic capture:** EN = 1, DW = 16, SCK = clk/8. Send frames L = 0xA5C3, R = 0x1234 ×3.
  - Response: the first partial frame is discarded. DATA reads 0xA5C31234. LEVEL decrements per read; EMPTY = 1 after the last read.
- **Overflow:** send 9 frames (L = n, R = ~n) with no reads, FIFO_DEPTH = 8.
  - Response: FULL = 1, OVERFLOW = 1, LEVEL = 8. Eight reads return frames 0..7 in order.
  - Writing STATUS = 0x4 then clears OVERFLOW.
- **Length mismatch:** send 24-bit words L = 0xABCDEF, R = 0x123456.
  - Response: DATA = 0xABCD1234.
  - With 12-bit words L = 0xFFF, R = 0x001: DATA = 0xFFF00010.
- **Disable mid-word:** clear EN during a left word, wait, then set EN again.
  - Response: no frame is pushed from the partial word, SYNCED = 0 until the next WS change, and existing FIFO contents are retained.
- **Empty read / flush:** read DATA while empty.
  - Response: 0 returned, LEVEL stays 0.
  - Fill 3 frames, then write CONTROL = 0x3 (EN and FLUSH): LEVEL = 0, EMPTY = 1, and capture continues.

Source files
------------

// File: rtl/avs_i2s_rx.sv
// rtl/avs_i2s_rx.sv - Avalon-MM slave I2S receiver with frame FIFO
//
// Oversamples an external I2S stream in the clk domain, assembles each
// left/right word pair into one 32-bit frame {left, right} (each channel
// left-aligned in its 16-bit half) and buffers frames for CPU readout.
//
// Ports:
//   clk, reset_n            system clock (>= 8x SCK), async active-low reset
//   avs_s0_address[1:0]     0 DATA, 1 CONTROL, 2 STATUS, 3 reserved
//   avs_s0_read/write       access strobes, zero wait states
//   avs_s0_readdata[31:0]   combinational, 0 when not reading
//   avs_s0_writedata[31:0]  write data
//   avs_s0_waitrequest      always 0
//   avs_s0_export_i2s_*     SCK / WS / SD from the codec, async to clk

module avs_i2s_rx #(
   parameter int DW         = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  avs_s0_address,
   input  logic        avs_s0_read,
   input  logic        avs_s0_write,
   output logic        avs_s0_waitrequest,
   output logic [31:0] avs_s0_readdata,
   input  logic [31:0] avs_s0_writedata,
   input  logic        avs_s0_export_i2s_sck,
   input  logic        avs_s0_export_i2s_ws,
   input  logic        avs_s0_export_i2s_sd
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(DW + 1);
   localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

   typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_RUN} state_t;

   // ------------------------------------------------------------------
   // Input synchronisers and SCK rise strobe
   // ------------------------------------------------------------------
   logic r_sck_meta, r_sck_sync, r_sck_prev;
   logic r_ws_meta,  r_ws_sync;
   logic r_sd_meta,  r_sd_sync;
   logic r_strobe, r_ws_q, r_sd_q;

   // The strobe is registered, so WS/SD are registered alongside it to
   // stay aligned with the edge they were sampled on.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sck_meta <= 1'b0;
         r_sck_sync <= 1'b0;
         r_sck_prev <= 1'b0;
         r_ws_meta  <= 1'b0;
         r_ws_sync  <= 1'b0;
         r_sd_meta  <= 1'b0;
         r_sd_sync  <= 1'b0;
         r_strobe   <= 1'b0;
         r_ws_q     <= 1'b0;
         r_sd_q     <= 1'b0;
      end else begin
         r_sck_meta <= avs_s0_export_i2s_sck;
         r_sck_sync <= r_sck_meta;
         r_sck_prev <= r_sck_sync;
         r_ws_meta  <= avs_s0_export_i2s_ws;
         r_ws_sync  <= r_ws_meta;
         r_sd_meta  <= avs_s0_export_i2s_sd;
         r_sd_sync  <= r_sd_meta;
         r_strobe   <= r_sck_sync & ~r_sck_prev;
         r_ws_q     <= r_ws_sync;
         r_sd_q     <= r_sd_sync;
      end
   end

   // ------------------------------------------------------------------
   // Register-side decode
   // ------------------------------------------------------------------
   logic r_en;
   logic r_ovf;
   logic [AW:0] r_wptr, r_rptr;
   logic [31:0] r_mem [FIFO_DEPTH];

   logic [AW:0] w_level;
   logic [6:0]  w_level7;
   logic        w_empty, w_full, w_pop, w_flush, w_wr, w_ovf_clr;

   assign w_level   = r_wptr - r_rptr;
   assign w_level7  = 7'(w_level);
   assign w_empty   = (w_level == '0);
   assign w_full    = (w_level == DEPTH_L);
   assign w_pop     = avs_s0_read  && (avs_s0_address == 2'd0) && !w_empty;
   assign w_flush   = avs_s0_write && (avs_s0_address == 2'd1) && avs_s0_writedata[1];
   assign w_ovf_clr = avs_s0_write && (avs_s0_address == 2'd2) && avs_s0_writedata[2];

   logic w_unused;
   assign w_unused = ^{avs_s0_writedata[31:3]};

   // ------------------------------------------------------------------
   // Capture FSM
   // ------------------------------------------------------------------
   state_t         r_state;
   logic [CW-1:0]  r_cnt;
   logic [DW-1:0]  r_sr;
   logic [DW-1:0]  r_left;
   logic           r_left_valid;
   logic           r_ws_prev;
   logic           r_synced;
   logic           r_push;
   logic [31:0]    r_push_data;

   logic           w_bit_ok;
   logic           w_ws_change;
   logic [DW-1:0]  w_sr_next;
   logic [15:0]    w_left16, w_right16;

   assign w_bit_ok    = (r_cnt < CW'(DW));
   assign w_ws_change = r_ws_q ^ r_ws_prev;

   // Shift register with the current SD bit placed at sr[DW-1-cnt];
   // once cnt saturates at DW further bits are ignored (truncation).
   always_comb begin
      w_sr_next = r_sr;
      for (int i = 0; i < DW; i++) begin
         if (w_bit_ok && (r_cnt == CW'(DW - 1 - i)))
            w_sr_next[i] = r_sd_q;
      end
   end

   // Left-align each channel in its 16-bit half, zero-filling the LSBs.
   assign w_left16  = 16'(r_left)    << (16 - DW);
   assign w_right16 = 16'(w_sr_next) << (16 - DW);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_sr         <= '0;
         r_left       <= '0;
         r_left_valid <= 1'b0;
         r_ws_prev    <= 1'b0;
         r_synced     <= 1'b0;
         r_push       <= 1'b0;
         r_push_data  <= '0;
      end else begin
         r_push <= 1'b0;
         // WS history is tracked in every state so HUNT has a reference.
         if (r_strobe)
            r_ws_prev <= r_ws_q;

         if (!r_en) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_sr         <= '0;
            r_synced     <= 1'b0;
            r_left_valid <= 1'b0;
         end else if (r_strobe) begin
            case (r_state)
               ST_IDLE: r_state <= ST_HUNT;
               ST_HUNT: begin
                  // The bit on the first WS change belongs to an
                  // unsynchronised word and is dropped.
                  if (w_ws_change) begin
                     r_synced <= 1'b1;
                     r_state  <= ST_RUN;
                     r_cnt    <= '0;
                     r_sr     <= '0;
                  end
               end
               ST_RUN: begin
                  if (!w_ws_change) begin
                     r_sr <= w_sr_next;
                     if (w_bit_ok)
                        r_cnt <= r_cnt + 1'b1;
                  end else begin
                     // This edge carries the outgoing word's LSB.
                     if (!r_ws_prev) begin
                        r_left       <= w_sr_next;
                        r_left_valid <= 1'b1;
                     end else if (r_left_valid) begin
                        r_push       <= 1'b1;
                        r_push_data  <= {w_left16, w_right16};
                        r_left_valid <= 1'b0;
                     end
                     r_sr  <= '0;
                     r_cnt <= '0;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // FIFO and control/status registers
   // ------------------------------------------------------------------
   // A push into a full FIFO still succeeds when a pop frees a slot in
   // the same cycle.
   assign w_wr = r_push && (!w_full || w_pop) && !w_flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_en   <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         if (avs_s0_write && (avs_s0_address == 2'd1))
            r_en <= avs_s0_writedata[0];

         if (w_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_wr)
               r_wptr <= r_wptr + 1'b1;
            if (w_pop)
               r_rptr <= r_rptr + 1'b1;
         end

         if (w_ovf_clr)
            r_ovf <= 1'b0;
         if (r_push && w_full && !w_pop && !w_flush)
            r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wptr[AW-1:0]] <= r_push_data;
   end

   assign avs_s0_waitrequest = 1'b0;

   always_comb begin
      avs_s0_readdata = 32'd0;
      if (avs_s0_read) begin
         case (avs_s0_address)
            2'd0: avs_s0_readdata = w_empty ? 32'd0 : r_mem[r_rptr[AW-1:0]];
            2'd1: avs_s0_readdata = {31'd0, r_en};
            2'd2: avs_s0_readdata = {17'd0, w_level7, 4'd0,
                                     r_synced, r_ovf, w_full, w_empty};
            default: avs_s0_readdata = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_avs_i2s_rx.sv
// tb/tb_avs_i2s_rx.sv - scoreboard testbench for avs_i2s_rx

module tb_avs_i2s_rx;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic        waitrequest;
   logic [31:0] readdata;
   logic [31:0] writedata = 32'd0;
   logic        sck = 1'b0;
   logic        ws = 1'b0;
   logic        sd = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] q_exp [$];

   avs_i2s_rx #(.DW(16), .FIFO_DEPTH(8)) dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .avs_s0_address        (address),
      .avs_s0_read           (read),
      .avs_s0_write          (write),
      .avs_s0_waitrequest    (waitrequest),
      .avs_s0_readdata       (readdata),
      .avs_s0_writedata      (writedata),
      .avs_s0_export_i2s_sck (sck),
      .avs_s0_export_i2s_ws  (ws),
      .avs_s0_export_i2s_sd  (sd)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a;
      read = 1'b1;
      #2;
      d = readdata;
      @(negedge clk);
      read = 1'b0;
   endtask

   task automatic chk(input logic [1:0] a, input logic [31:0] exp, input string name);
      logic [31:0] d;
      rd(a, d);
      check(name, d, exp);
   endtask

   task automatic rd_data();
      logic [31:0] d;
      rd(2'd0, d);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a;
      writedata = d;
      write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic settle();
      repeat (10) @(negedge clk);
   endtask

   // One SCK period (80 ns = 8 clk): data/WS change while SCK is low.
   task automatic slot(input logic w, input logic s);
      sck = 1'b0;
      ws  = w;
      sd  = s;
      #40;
      sck = 1'b1;
      #40;
   endtask

   // WS flips on the LSB slot, one bit before the next word's MSB.
   task automatic send_word(input logic [31:0] v, input int nb, input logic ch);
      for (int i = nb - 1; i >= 0; i--)
         slot((i == 0) ? ~ch : ch, v[i]);
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nb);
      send_word(l, nb, 1'b0);
      send_word(r, nb, 1'b1);
   endtask

   // Syncs into a right word, which has no left partner and is dropped.
   task automatic preamble();
      repeat (3) slot(1'b0, 1'b0);
      slot(1'b1, 1'b1);
      send_word(32'h0000DEAD, 16, 1'b1);
   endtask

   // Monitor: every DATA read is compared with the scoreboard head.
   initial begin
      logic [31:0] exp;
      forever begin
         @(negedge clk);
         #3;
         if (read && (address == 2'd0)) begin
            exp = (q_exp.size() > 0) ? q_exp.pop_front() : 32'd0;
            check("data", readdata, exp);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [31:0] ovf_tab [8];
      ovf_tab = '{32'h0000FFFF, 32'h0001FFFE, 32'h0002FFFD, 32'h0003FFFC,
                  32'h0004FFFB, 32'h0005FFFA, 32'h0006FFF9, 32'h0007FFF8};

      // Reset state
      repeat (3) @(negedge clk);
      chk(2'd2, 32'h00000001, "rst_status");
      chk(2'd1, 32'h00000000, "rst_ctrl");
      rd_data();
      check("rst_waitreq", {31'd0, waitrequest}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // Basic capture; the first partial frame is dropped
      wr(2'd1, 32'h1);
      preamble();
      repeat (3) begin
         send_frame(32'hA5C3, 32'h1234, 16);
         q_exp.push_back(32'hA5C31234);
      end
      settle();
      chk(2'd2, 32'h00000308, "basic_lvl3");
      rd_data();
      chk(2'd2, 32'h00000208, "basic_lvl2");
      rd_data();
      chk(2'd2, 32'h00000108, "basic_lvl1");
      rd_data();
      chk(2'd2, 32'h00000009, "basic_empty");

      // Overflow: nine frames into an 8-deep FIFO
      for (int n = 0; n < 9; n++)
         send_frame(32'(n), 32'(16'hFFFF ^ 16'(n)), 16);
      for (int n = 0; n < 8; n++)
         q_exp.push_back(ovf_tab[n]);
      settle();
      chk(2'd2, 32'h0000080E, "ovf_full");
      wr(2'd2, 32'h4);
      chk(2'd2, 32'h0000080A, "ovf_clear");
      repeat (8) rd_data();
      chk(2'd2, 32'h00000009, "ovf_drained");

      // Length mismatch: 24-bit truncation, 12-bit zero padding
      send_frame(32'hABCDEF, 32'h123456, 24);
      q_exp.push_back(32'hABCD1234);
      send_frame(32'hFFF, 32'h001, 12);
      q_exp.push_back(32'hFFF00010);
      settle();
      chk(2'd2, 32'h00000208, "len_lvl2");
      rd_data();
      rd_data();

      // Disable mid-word
      send_frame(32'h1111, 32'h2222, 16);
      q_exp.push_back(32'h11112222);
      settle();
      repeat (8) slot(1'b0, 1'b1);
      wr(2'd1, 32'h0);
      repeat (5) @(negedge clk);
      chk(2'd2, 32'h00000100, "dis_unsynced");
      chk(2'd1, 32'h00000000, "dis_ctrl");
      wr(2'd1, 32'h1);
      repeat (5) @(negedge clk);
      chk(2'd2, 32'h00000100, "reen_hunt");
      preamble();
      send_frame(32'h3333, 32'h4444, 16);
      q_exp.push_back(32'h33334444);
      settle();
      chk(2'd2, 32'h00000208, "reen_synced");
      rd_data();
      rd_data();

      // Empty read, then flush
      rd_data();
      chk(2'd2, 32'h00000009, "empty_read");
      repeat (3) begin
         send_frame(32'h5A5A, 32'hC3C3, 16);
         q_exp.push_back(32'h5A5AC3C3);
      end
      settle();
      chk(2'd2, 32'h00000308, "flush_pre");
      wr(2'd1, 32'h3);
      q_exp.delete();
      chk(2'd2, 32'h00000009, "flush_post");
      chk(2'd1, 32'h00000001, "flush_ctrl");
      send_frame(32'h7777, 32'h8888, 16);
      q_exp.push_back(32'h77778888);
      settle();
      chk(2'd2, 32'h00000108, "flush_continue");
      rd_data();

      // Reset mid-traffic
      send_frame(32'h9999, 32'hAAAA, 16);
      settle();
      repeat (5) slot(1'b0, 1'b1);
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk(2'd2, 32'h00000001, "mrst_status");
      chk(2'd1, 32'h00000000, "mrst_ctrl");
      rd_data();
      check("mrst_waitreq", {31'd0, waitrequest}, 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
